// File: rtl/vram_arbiter.sv
// Arbitrates a single-port SRAM between display scanout (read, high priority) and the GPU (read/write).
// Defining VRAM_ARB_STATS_EN adds saturating stall counters o_stat_disp_stall / o_stat_gpu_stall.
module vram_arbiter #(
  parameter int unsigned ADDR_W         = 18,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned DISP_BURST_MAX = 4,
  parameter int unsigned TURNAROUND     = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_disp_req,
  input  logic [ADDR_W-1:0] i_disp_addr,
  output logic              o_disp_gnt,
  output logic [DATA_W-1:0] o_disp_data,
  output logic              o_disp_valid,
  input  logic              i_gpu_req,
  input  logic              i_gpu_we,
  input  logic [ADDR_W-1:0] i_gpu_addr,
  input  logic [DATA_W-1:0] i_gpu_wdata,
  output logic              o_gpu_gnt,
  output logic [DATA_W-1:0] o_gpu_rdata,
  output logic              o_gpu_rvalid,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_wdata,
  output logic              o_sram_oe,
  output logic              o_sram_we_n,
  output logic              o_sram_oe_n,
  input  logic [DATA_W-1:0] i_sram_rdata
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0]       o_stat_disp_stall,
  output logic [15:0]       o_stat_gpu_stall
`endif
);

  localparam int unsigned   BW        = $clog2(DISP_BURST_MAX + 2);
  localparam int unsigned   TW        = 2;
  localparam logic [BW-1:0] BURST_LIM = BW'(DISP_BURST_MAX);
  localparam logic [TW-1:0] TURN_LOAD = TW'((TURNAROUND == 0) ? 0 : TURNAROUND - 1);

  typedef enum logic [1:0] {READY, WRITE, TURN} state_e;

  state_e            state_q, state_d;
  logic [BW-1:0]     burst_q, burst_d;
  logic [TW-1:0]     turn_q, turn_d;
  logic              rd_vld_q, rd_vld_d;
  logic              rd_gpu_q, rd_gpu_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_n_q, we_n_d, oe_n_q, oe_n_d, oe_q, oe_d;
  logic              disp_vld_q, disp_vld_d, gpu_vld_q, gpu_vld_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d, gpu_data_q, gpu_data_d;
  logic              gpu_win, disp_gnt, gpu_gnt;

  // Arbitration, burst accounting, pin sequencing and read-result routing
  always_comb begin
    gpu_win  = i_gpu_req && (!i_disp_req || (DISP_BURST_MAX != 0 && burst_q == BURST_LIM));
    gpu_gnt  = i_rst_n && (state_q == READY) && gpu_win;
    disp_gnt = i_rst_n && (state_q == READY) && !gpu_win && i_disp_req;

    state_d     = state_q;
    turn_d      = turn_q;
    burst_d     = burst_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    oe_d        = 1'b0;
    rd_vld_d    = 1'b0;
    rd_gpu_d    = 1'b0;
    disp_vld_d  = rd_vld_q && !rd_gpu_q;
    gpu_vld_d   = rd_vld_q && rd_gpu_q;
    disp_data_d = disp_vld_d ? i_sram_rdata : disp_data_q;
    gpu_data_d  = gpu_vld_d ? i_sram_rdata : gpu_data_q;

    if (!i_gpu_req || gpu_gnt) begin
      burst_d = '0;
    end else if (disp_gnt && burst_q != BURST_LIM) begin
      burst_d = burst_q + BW'(1);
    end

    case (state_q)
      READY: begin
        if (gpu_gnt) begin
          addr_d = i_gpu_addr;
          if (i_gpu_we) begin
            wdata_d = i_gpu_wdata;
            we_n_d  = 1'b0;
            oe_d    = 1'b1;
            state_d = WRITE;
          end else begin
            oe_n_d   = 1'b0;
            rd_vld_d = 1'b1;
            rd_gpu_d = 1'b1;
          end
        end else if (disp_gnt) begin
          addr_d   = i_disp_addr;
          oe_n_d   = 1'b0;
          rd_vld_d = 1'b1;
        end
      end
      WRITE: begin
        if (TURNAROUND == 0) begin
          state_d = READY;
        end else begin
          state_d = TURN;
          turn_d  = TURN_LOAD;
        end
      end
      TURN: begin
        if (turn_q == '0) state_d = READY;
        else              turn_d  = turn_q - TW'(1);
      end
      default: state_d = READY;
    endcase
  end

  // Reset forces we_n high immediately, aborting any write on the pins
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= READY;
      burst_q     <= '0;
      turn_q      <= '0;
      rd_vld_q    <= 1'b0;
      rd_gpu_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      oe_q        <= 1'b0;
      disp_vld_q  <= 1'b0;
      gpu_vld_q   <= 1'b0;
      disp_data_q <= '0;
      gpu_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      burst_q     <= burst_d;
      turn_q      <= turn_d;
      rd_vld_q    <= rd_vld_d;
      rd_gpu_q    <= rd_gpu_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      oe_q        <= oe_d;
      disp_vld_q  <= disp_vld_d;
      gpu_vld_q   <= gpu_vld_d;
      disp_data_q <= disp_data_d;
      gpu_data_q  <= gpu_data_d;
    end
  end

  assign o_disp_gnt   = disp_gnt;
  assign o_gpu_gnt    = gpu_gnt;
  assign o_disp_valid = disp_vld_q;
  assign o_disp_data  = disp_data_q;
  assign o_gpu_rvalid = gpu_vld_q;
  assign o_gpu_rdata  = gpu_data_q;
  assign o_sram_addr  = addr_q;
  assign o_sram_wdata = wdata_q;
  assign o_sram_oe    = oe_q;
  assign o_sram_we_n  = we_n_q;
  assign o_sram_oe_n  = oe_n_q;

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] disp_stall_q, gpu_stall_q;

  // Cycles spent requesting without a grant, saturating
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      disp_stall_q <= '0;
      gpu_stall_q  <= '0;
    end else begin
      if (i_disp_req && !disp_gnt && disp_stall_q != 16'hFFFF) disp_stall_q <= disp_stall_q + 16'd1;
      if (i_gpu_req && !gpu_gnt && gpu_stall_q != 16'hFFFF)    gpu_stall_q  <= gpu_stall_q + 16'd1;
    end
  end

  assign o_stat_disp_stall = disp_stall_q;
  assign o_stat_gpu_stall  = gpu_stall_q;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: three configurations checked against a cycle-level reference model,
// plus a hand-derived vector table and directed burst/reset sequences.
module tb_vram_arbiter;

  localparam int unsigned AW = 18;
  localparam int unsigned DW = 16;
  localparam int NI = 3;

  function automatic int unsigned bmax(input int k);
    case (k)
      0:       return 4;
      1:       return 0;
      default: return 2;
    endcase
  endfunction

  function automatic int unsigned tround(input int k);
    case (k)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          disp_req   [NI];
  logic [AW-1:0] disp_addr  [NI];
  logic          gpu_req    [NI];
  logic          gpu_we     [NI];
  logic [AW-1:0] gpu_addr   [NI];
  logic [DW-1:0] gpu_wdata  [NI];
  logic          disp_gnt   [NI];
  logic [DW-1:0] disp_data  [NI];
  logic          disp_valid [NI];
  logic          gpu_gnt    [NI];
  logic [DW-1:0] gpu_rdata  [NI];
  logic          gpu_rvalid [NI];
  logic [AW-1:0] sram_addr  [NI];
  logic [DW-1:0] sram_wdata [NI];
  logic          sram_oe    [NI];
  logic          sram_we_n  [NI];
  logic          sram_oe_n  [NI];
  logic [DW-1:0] sram_rdata [NI];
`ifdef VRAM_ARB_STATS_EN
  logic [15:0]   stat_disp  [NI];
  logic [15:0]   stat_gpu   [NI];
`endif

  for (genvar g = 0; g < NI; g++) begin : g_dut
    vram_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .DISP_BURST_MAX(bmax(g)), .TURNAROUND(tround(g))
    ) u_dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_disp_req(disp_req[g]), .i_disp_addr(disp_addr[g]),
      .o_disp_gnt(disp_gnt[g]), .o_disp_data(disp_data[g]), .o_disp_valid(disp_valid[g]),
      .i_gpu_req(gpu_req[g]), .i_gpu_we(gpu_we[g]), .i_gpu_addr(gpu_addr[g]),
      .i_gpu_wdata(gpu_wdata[g]),
      .o_gpu_gnt(gpu_gnt[g]), .o_gpu_rdata(gpu_rdata[g]), .o_gpu_rvalid(gpu_rvalid[g]),
      .o_sram_addr(sram_addr[g]), .o_sram_wdata(sram_wdata[g]), .o_sram_oe(sram_oe[g]),
      .o_sram_we_n(sram_we_n[g]), .o_sram_oe_n(sram_oe_n[g]), .i_sram_rdata(sram_rdata[g])
`ifdef VRAM_ARB_STATS_EN
      , .o_stat_disp_stall(stat_disp[g]), .o_stat_gpu_stall(stat_gpu[g])
`endif
    );
    // SRAM model: each word reads back as the low 16 bits of its address
    assign sram_rdata[g] = sram_addr[g][DW-1:0];
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h want %0h (cycle %0d)", nm, k, act, exp, cyc);
    end
  endtask

  // Reference model: blocked-cycle countdown after writes, display streak, results scheduled by time
  int            m_busy   [NI];
  int            m_streak [NI];
  int            m_sd     [NI];
  int            m_sg     [NI];
  bit            m_dg     [NI];
  bit            m_gg     [NI];
  bit            a_dg     [NI];
  bit            a_gg     [NI];
  logic [AW-1:0] e_addr   [NI];
  logic [DW-1:0] e_wdata  [NI];
  bit            e_we_n   [NI];
  bit            e_oe_n   [NI];
  bit            e_oe     [NI];
  bit            slot_v   [NI][4];
  bit            slot_g   [NI][4];
  logic [DW-1:0] slot_d   [NI][4];

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_busy[k] = 0; m_streak[k] = 0; m_sd[k] = 0; m_sg[k] = 0;
      e_addr[k] = '0; e_wdata[k] = '0; e_we_n[k] = 1'b1; e_oe_n[k] = 1'b1; e_oe[k] = 1'b0;
      for (int s = 0; s < 4; s++) begin
        slot_v[k][s] = 1'b0; slot_g[k][s] = 1'b0; slot_d[k][s] = '0;
      end
    end
  endtask

  // Inputs already driven for this cycle: check grants, advance model, then check registered outputs
  task automatic run_cycle();
    #1;
    for (int k = 0; k < NI; k++) begin
      bit blk, gw, eg, ed;
      int bm;
      logic [AW-1:0] ra;
      bm  = int'(bmax(k));
      blk = m_busy[k] > 0;
      gw  = gpu_req[k] && (!disp_req[k] || (bm != 0 && m_streak[k] == bm));
      eg  = !blk && gw;
      ed  = !blk && !gw && disp_req[k];
      chk("disp_gnt", k, 32'(disp_gnt[k]), 32'(ed));
      chk("gpu_gnt", k, 32'(gpu_gnt[k]), 32'(eg));
      a_dg[k] = disp_gnt[k]; a_gg[k] = gpu_gnt[k];
      m_dg[k] = ed;          m_gg[k] = eg;
      if (disp_req[k] && !ed && m_sd[k] < 65535) m_sd[k]++;
      if (gpu_req[k] && !eg && m_sg[k] < 65535)  m_sg[k]++;
      if (!gpu_req[k] || eg) m_streak[k] = 0;
      else if (ed && m_streak[k] < bm) m_streak[k]++;
      e_we_n[k] = 1'b1; e_oe_n[k] = 1'b1; e_oe[k] = 1'b0;
      if (eg && gpu_we[k]) begin
        e_addr[k] = gpu_addr[k]; e_wdata[k] = gpu_wdata[k];
        e_we_n[k] = 1'b0; e_oe[k] = 1'b1;
        m_busy[k] = 1 + int'(tround(k));
      end else begin
        if (m_busy[k] > 0) m_busy[k]--;
        if (eg || ed) begin
          ra = eg ? gpu_addr[k] : disp_addr[k];
          e_addr[k] = ra; e_oe_n[k] = 1'b0;
          slot_v[k][(cyc + 2) % 4] = 1'b1;
          slot_g[k][(cyc + 2) % 4] = eg;
          slot_d[k][(cyc + 2) % 4] = ra[DW-1:0];
        end
      end
    end
    @(posedge clk); #1;
    cyc++;
    for (int k = 0; k < NI; k++) begin
      bit xd, xg;
      xd = slot_v[k][cyc % 4] && !slot_g[k][cyc % 4];
      xg = slot_v[k][cyc % 4] && slot_g[k][cyc % 4];
      chk("disp_valid", k, 32'(disp_valid[k]), 32'(xd));
      chk("gpu_rvalid", k, 32'(gpu_rvalid[k]), 32'(xg));
      if (xd) chk("disp_data", k, 32'(disp_data[k]), 32'(slot_d[k][cyc % 4]));
      if (xg) chk("gpu_rdata", k, 32'(gpu_rdata[k]), 32'(slot_d[k][cyc % 4]));
      slot_v[k][cyc % 4] = 1'b0;
      chk("sram_we_n", k, 32'(sram_we_n[k]), 32'(e_we_n[k]));
      chk("sram_oe_n", k, 32'(sram_oe_n[k]), 32'(e_oe_n[k]));
      chk("sram_oe", k, 32'(sram_oe[k]), 32'(e_oe[k]));
      chk("sram_addr", k, 32'(sram_addr[k]), 32'(e_addr[k]));
      if (!e_we_n[k]) chk("sram_wdata", k, 32'(sram_wdata[k]), 32'(e_wdata[k]));
`ifdef VRAM_ARB_STATS_EN
      chk("stat_disp", k, 32'(stat_disp[k]), 32'(m_sd[k]));
      chk("stat_gpu", k, 32'(stat_gpu[k]), 32'(m_sg[k]));
`endif
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("rst_we_n", k, 32'(sram_we_n[k]), 32'd1);
      chk("rst_oe_n", k, 32'(sram_oe_n[k]), 32'd1);
      chk("rst_oe", k, 32'(sram_oe[k]), 32'd0);
      chk("rst_addr", k, 32'(sram_addr[k]), 32'd0);
      chk("rst_valids", k, 32'({disp_valid[k], gpu_rvalid[k]}), 32'd0);
      chk("rst_gnts", k, 32'({disp_gnt[k], gpu_gnt[k]}), 32'd0);
`ifdef VRAM_ARB_STATS_EN
      chk("rst_stats", k, 32'({stat_disp[k], stat_gpu[k]}), 32'd0);
`endif
    end
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic drive_all(input logic dr, input logic [AW-1:0] da, input logic gr, input logic gw,
                           input logic [AW-1:0] ga, input logic [DW-1:0] gd);
    for (int k = 0; k < NI; k++) begin
      disp_req[k] = dr; disp_addr[k] = da;
      gpu_req[k] = gr; gpu_we[k] = gw; gpu_addr[k] = ga; gpu_wdata[k] = gd;
    end
  endtask

  typedef struct packed {
    logic dr; logic [AW-1:0] da; logic gr; logic gw; logic [AW-1:0] ga; logic [DW-1:0] gd;
    logic x_dg; logic x_gg; logic x_we_n; logic x_oe_n; logic x_oe; logic [AW-1:0] x_addr;
    logic x_dv; logic x_gv; logic [DW-1:0] x_data;
  } vec_t;

  function automatic vec_t mk(input logic dr, input logic [AW-1:0] da, input logic gr, input logic gw,
                              input logic [AW-1:0] ga, input logic [DW-1:0] gd,
                              input logic xdg, input logic xgg, input logic xwen, input logic xoen,
                              input logic xoe, input logic [AW-1:0] xa, input logic xdv,
                              input logic xgv, input logic [DW-1:0] xdat);
    return '{dr, da, gr, gw, ga, gd, xdg, xgg, xwen, xoen, xoe, xa, xdv, xgv, xdat};
  endfunction

  vec_t tbl [14];
  int   dcnt [NI];
  int   gcnt [NI];
  logic [9:0] gseq [NI];
  logic [9:0] dseq [NI];

  initial begin
    // Expected outputs for configuration 0 (burst 4, turnaround 1); outputs are those after the edge
    tbl[0]  = mk(1, 18'h00010, 0, 0, 18'h0, 16'h0,    1, 0, 1, 0, 0, 18'h00010, 0, 0, 16'h0000);
    tbl[1]  = mk(1, 18'h00011, 0, 0, 18'h0, 16'h0,    1, 0, 1, 0, 0, 18'h00011, 1, 0, 16'h0010);
    tbl[2]  = mk(1, 18'h00012, 0, 0, 18'h0, 16'h0,    1, 0, 1, 0, 0, 18'h00012, 1, 0, 16'h0011);
    tbl[3]  = mk(1, 18'h00013, 0, 0, 18'h0, 16'h0,    1, 0, 1, 0, 0, 18'h00013, 1, 0, 16'h0012);
    tbl[4]  = mk(0, 18'h0,     0, 0, 18'h0, 16'h0,    0, 0, 1, 1, 0, 18'h00013, 1, 0, 16'h0013);
    tbl[5]  = mk(0, 18'h0,     0, 0, 18'h0, 16'h0,    0, 0, 1, 1, 0, 18'h00013, 0, 0, 16'h0000);
    tbl[6]  = mk(0, 18'h0,     1, 1, 18'h3FFFF, 16'hF800, 0, 1, 0, 1, 1, 18'h3FFFF, 0, 0, 16'h0000);
    tbl[7]  = mk(1, 18'h00020, 0, 0, 18'h0, 16'h0,    0, 0, 1, 1, 0, 18'h3FFFF, 0, 0, 16'h0000);
    tbl[8]  = mk(1, 18'h00020, 0, 0, 18'h0, 16'h0,    0, 0, 1, 1, 0, 18'h3FFFF, 0, 0, 16'h0000);
    tbl[9]  = mk(1, 18'h00020, 0, 0, 18'h0, 16'h0,    1, 0, 1, 0, 0, 18'h00020, 0, 0, 16'h0000);
    tbl[10] = mk(0, 18'h0,     0, 0, 18'h0, 16'h0,    0, 0, 1, 1, 0, 18'h00020, 1, 0, 16'h0020);
    tbl[11] = mk(0, 18'h0,     1, 0, 18'h0ABCD, 16'h0, 0, 1, 1, 0, 0, 18'h0ABCD, 0, 0, 16'h0000);
    tbl[12] = mk(0, 18'h0,     0, 0, 18'h0, 16'h0,    0, 0, 1, 1, 0, 18'h0ABCD, 0, 1, 16'hABCD);
    tbl[13] = mk(0, 18'h0,     0, 0, 18'h0, 16'h0,    0, 0, 1, 1, 0, 18'h0ABCD, 0, 0, 16'h0000);

    rst_n = 1'b1;
    drive_all(1'b0, '0, 1'b0, 1'b0, '0, '0);
    model_reset();
    #3;
    do_reset();

    repeat (10) run_cycle();

    for (int i = 0; i < 14; i++) begin
      drive_all(tbl[i].dr, tbl[i].da, tbl[i].gr, tbl[i].gw, tbl[i].ga, tbl[i].gd);
      run_cycle();
      chk("tbl_dgnt", i, 32'(a_dg[0]), 32'(tbl[i].x_dg));
      chk("tbl_ggnt", i, 32'(a_gg[0]), 32'(tbl[i].x_gg));
      chk("tbl_pins", i, 32'({sram_we_n[0], sram_oe_n[0], sram_oe[0]}),
          32'({tbl[i].x_we_n, tbl[i].x_oe_n, tbl[i].x_oe}));
      chk("tbl_addr", i, 32'(sram_addr[0]), 32'(tbl[i].x_addr));
      chk("tbl_valid", i, 32'({disp_valid[0], gpu_rvalid[0]}), 32'({tbl[i].x_dv, tbl[i].x_gv}));
      if (!tbl[i].x_we_n) chk("tbl_wdata", i, 32'(sram_wdata[0]), 32'(tbl[i].gd));
      if (tbl[i].x_dv) chk("tbl_ddata", i, 32'(disp_data[0]), 32'(tbl[i].x_data));
      if (tbl[i].x_gv) chk("tbl_gdata", i, 32'(gpu_rdata[0]), 32'(tbl[i].x_data));
    end
    repeat (4) run_cycle();

    // Both requesters held continuously; addresses advance only when granted
    for (int k = 0; k < NI; k++) begin
      dcnt[k] = 0; gcnt[k] = 0; gseq[k] = '0; dseq[k] = '0;
    end
    for (int c = 0; c < 10; c++) begin
      for (int k = 0; k < NI; k++) begin
        disp_req[k] = 1'b1; disp_addr[k] = AW'(32'h100 + dcnt[k]);
        gpu_req[k] = 1'b1; gpu_we[k] = 1'b0; gpu_addr[k] = AW'(32'h200 + gcnt[k]);
      end
      run_cycle();
      for (int k = 0; k < NI; k++) begin
        gseq[k][c] = a_gg[k]; dseq[k][c] = a_dg[k];
        if (m_dg[k]) dcnt[k]++;
        if (m_gg[k]) gcnt[k]++;
      end
    end
    chk("burst4_gseq", 0, 32'(gseq[0]), 32'h210);
    chk("burst4_dseq", 0, 32'(dseq[0]), 32'h1EF);
    chk("strict_gseq", 1, 32'(gseq[1]), 32'h000);
    chk("strict_dseq", 1, 32'(dseq[1]), 32'h3FF);
    chk("burst2_gseq", 2, 32'(gseq[2]), 32'h124);
    for (int k = 0; k < NI; k++) disp_req[k] = 1'b0;
    run_cycle();
    chk("strict_drop_ggnt", 1, 32'(a_gg[1]), 32'd1);
    drive_all(1'b0, '0, 1'b0, 1'b0, '0, '0);
    repeat (4) run_cycle();

    // Reset in the cycle after a display grant: the pending result must vanish
    drive_all(1'b1, 18'h00055, 1'b0, 1'b0, '0, '0);
    run_cycle();
    drive_all(1'b0, '0, 1'b0, 1'b0, '0, '0);
    do_reset();
    repeat (4) run_cycle();

    // Reset mid-write: we_n must return high without a clock edge
    drive_all(1'b0, '0, 1'b1, 1'b1, 18'h01234, 16'h07E0);
    run_cycle();
    drive_all(1'b0, '0, 1'b0, 1'b0, '0, '0);
    #2;
    do_reset();
    repeat (4) run_cycle();

    // Randomized traffic with request/hold handshaking and occasional reset
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NI; k++) begin
        if (!disp_req[k] && $urandom_range(0, 99) < 60) begin
          disp_req[k] = 1'b1; disp_addr[k] = AW'($urandom);
        end
        if (!gpu_req[k] && $urandom_range(0, 99) < 40) begin
          gpu_req[k] = 1'b1; gpu_we[k] = 1'($urandom_range(0, 1));
          gpu_addr[k] = AW'($urandom); gpu_wdata[k] = DW'($urandom);
        end
      end
      run_cycle();
      for (int k = 0; k < NI; k++) begin
        if (m_dg[k]) disp_req[k] = 1'b0;
        if (m_gg[k]) gpu_req[k] = 1'b0;
      end
      if ($urandom_range(0, 599) == 0) do_reset();
    end

    drive_all(1'b0, '0, 1'b0, 1'b0, '0, '0);
    repeat (4) run_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
